// File: rtl/addition_subtraction_pkg.sv
// Shared binary32 field widths, constants and the stage bundle
// passed from alignment to normalisation.
package addition_subtraction_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 1;
    localparam int BIAS  = 127;

    localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_TOP  = EXP_W'(2 * BIAS);
    localparam logic [31:0]      POS_ZERO = 32'h0;

    typedef struct packed {
        logic             valid;
        logic             exc;
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [SIG_W:0]   sum;
    } align_t;

endpackage

// File: rtl/addition_subtraction_if.sv
// Operand/result bundle of the binary32 adder/subtractor.
// slave = the adder, master = whoever drives operands.
interface addition_subtraction_if;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        AddBar_Sub;
    logic        in_valid;
    logic        Exception;
    logic [31:0] result;
    logic        out_valid;

    modport slave (
        input  a_operand, b_operand, AddBar_Sub, in_valid,
        output Exception, result, out_valid
    );

    modport master (
        output a_operand, b_operand, AddBar_Sub, in_valid,
        input  Exception, result, out_valid
    );
endinterface

// File: rtl/addition_subtraction_lzc.sv
// fp_lzc24: combinational leading-zero count of a 24-bit significand.
// Ports: din (24b) in, cnt (5b) out; all-zero input gives 24.
module fp_lzc24
    import addition_subtraction_pkg::*;
(
    input  logic [SIG_W-1:0] din,
    output logic [4:0]       cnt
);
    always_comb begin
        cnt = 5'd24;
        // Ascending scan: the highest set bit is written last and wins.
        for (int i = 0; i < SIG_W; i++) begin
            if (din[i]) cnt = 5'(SIG_W - 1 - i);
        end
    end
endmodule

// File: rtl/addition_subtraction.sv
// Truncating binary32 add/subtract, 1-cycle latency (2 with
// ADDITION_SUBTRACTION_PIPE_EN). Ports: clk, reset (async, high), bus.
module addition_subtraction
    import addition_subtraction_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    addition_subtraction_if.slave bus
);
    logic [31:0]      a, b;
    logic             a_ge, sign_a, sign_b, sign_l;
    logic [EXP_W-1:0] exp_a, exp_b, exp_l, exp_s, diff;
    logic [SIG_W-1:0] sig_a, sig_b, sig_l, sig_s, sig_s_sh;
    align_t           stg_d, nrm;

    assign a = bus.a_operand;
    assign b = bus.b_operand;

    // Alignment: pick the larger magnitude, shift the smaller, add/sub.
    always_comb begin
        sign_a = a[31];
        sign_b = b[31] ^ bus.AddBar_Sub;
        exp_a  = a[30:23];
        exp_b  = b[30:23];
        sig_a  = {exp_a != '0, a[22:0]};
        sig_b  = {exp_b != '0, b[22:0]};
        a_ge   = a[30:0] >= b[30:0];
        sign_l = a_ge ? sign_a : sign_b;
        exp_l  = a_ge ? exp_a : exp_b;
        exp_s  = a_ge ? exp_b : exp_a;
        sig_l  = a_ge ? sig_a : sig_b;
        sig_s  = a_ge ? sig_b : sig_a;
        diff   = exp_l - exp_s;
        sig_s_sh = (diff >= 8'd24) ? '0 : sig_s >> diff;

        stg_d.valid   = bus.in_valid;
        stg_d.exc     = (exp_a == EXP_MAX) || (exp_b == EXP_MAX);
        stg_d.sign    = sign_l;
        stg_d.eff_sub = sign_a ^ sign_b;
        stg_d.exp     = exp_l;
        // Larger magnitude first, so the difference never goes negative.
        if (stg_d.eff_sub)
            stg_d.sum = {1'b0, sig_l} - {1'b0, sig_s_sh};
        else
            stg_d.sum = {1'b0, sig_l} + {1'b0, sig_s_sh};
    end

`ifdef ADDITION_SUBTRACTION_PIPE_EN
    align_t stg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stg_q <= '0;
        else       stg_q <= stg_d;
    end

    assign nrm = stg_q;
`else
    assign nrm = stg_d;
`endif

    logic [4:0]       lz;
    logic [MAN_W-1:0] man_sh;
    logic [31:0]      res;
    logic [31:0]      result_d, result_q;
    logic             exc_d, exc_q, valid_d, valid_q;

    fp_lzc24 u_lzc (
        .din (nrm.sum[SIG_W-1:0]),
        .cnt (lz)
    );

    // Normalisation and packing.
    always_comb begin
        res    = POS_ZERO;
        // The leading one falls off the top, leaving the fraction.
        man_sh = nrm.sum[MAN_W-1:0] << lz;
        if (nrm.exc) begin
            res = POS_ZERO;
        end else if (nrm.eff_sub) begin
            if (nrm.sum == '0 || {3'b0, lz} >= nrm.exp)
                res = POS_ZERO;
            else
                res = {nrm.sign, nrm.exp - {3'b0, lz}, man_sh};
        end else if (nrm.sum[SIG_W]) begin
            if (nrm.exp >= EXP_TOP)
                res = {nrm.sign, EXP_MAX, {MAN_W{1'b0}}};
            else
                res = {nrm.sign, nrm.exp + 8'd1, nrm.sum[SIG_W-1:1]};
        end else if (nrm.exp == '0 && nrm.sum[MAN_W]) begin
            // Two denormals summed into the normal range.
            res = {nrm.sign, 8'd1, nrm.sum[MAN_W-1:0]};
        end else begin
            res = {nrm.sign, nrm.exp, nrm.sum[MAN_W-1:0]};
        end

        valid_d  = nrm.valid;
        result_d = nrm.valid ? res : result_q;
        exc_d    = nrm.valid ? nrm.exc : exc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= POS_ZERO;
            exc_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            exc_q    <= exc_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.Exception = exc_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_addition_subtraction.sv
// Directed scoreboard bench for addition_subtraction.
// Expected values are hand-derived binary32 constants.
module tb_addition_subtraction;
`ifdef ADDITION_SUBTRACTION_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] exp_res_q[$];
    logic        exp_exc_q[$];
    string       tag_q[$];
    logic [31:0] last_res = '0;
    logic        last_exc = 1'b0;

    addition_subtraction_if bus ();

    addition_subtraction dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        logic [31:0] er;
        logic        ee;
        string       tg;
        @(posedge clk);
        #1;
        if (!reset && bus.out_valid) begin
            total++;
            assert (exp_res_q.size() != 0) else begin
                bad++;
                $error("FAIL spurious out_valid result=%h", bus.result);
            end
            if (exp_res_q.size() != 0) begin
                er = exp_res_q.pop_front();
                ee = exp_exc_q.pop_front();
                tg = tag_q.pop_front();
                total++;
                assert (bus.result === er) else begin
                    bad++;
                    $error("FAIL %s result got=%h want=%h", tg, bus.result, er);
                end
                total++;
                assert (bus.Exception === ee) else begin
                    bad++;
                    $error("FAIL %s exc got=%b want=%b", tg, bus.Exception, ee);
                end
                last_res = er;
                last_exc = ee;
            end
        end
    endtask

    task automatic send(input string tg, input logic [31:0] a,
                        input logic [31:0] b, input logic op,
                        input logic [31:0] er, input logic ee);
        bus.a_operand  = a;
        bus.b_operand  = b;
        bus.AddBar_Sub = op;
        bus.in_valid   = 1'b1;
        exp_res_q.push_back(er);
        exp_exc_q.push_back(ee);
        tag_q.push_back(tg);
        tick();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_hold(input string tg);
        total++;
        assert (bus.out_valid === 1'b0) else begin
            bad++;
            $error("FAIL %s out_valid got=%b want=0", tg, bus.out_valid);
        end
        total++;
        assert (bus.result === last_res) else begin
            bad++;
            $error("FAIL %s hold got=%h want=%h", tg, bus.result, last_res);
        end
        total++;
        assert (bus.Exception === last_exc) else begin
            bad++;
            $error("FAIL %s hold exc got=%b want=%b", tg, bus.Exception, last_exc);
        end
    endtask

    task automatic check_zero(input string tg);
        total++;
        assert (bus.result === 32'h0) else begin
            bad++;
            $error("FAIL %s result got=%h want=0", tg, bus.result);
        end
        total++;
        assert (bus.Exception === 1'b0) else begin
            bad++;
            $error("FAIL %s exc got=%b want=0", tg, bus.Exception);
        end
        total++;
        assert (bus.out_valid === 1'b0) else begin
            bad++;
            $error("FAIL %s out_valid got=%b want=0", tg, bus.out_valid);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.a_operand  = '0;
        bus.b_operand  = '0;
        bus.AddBar_Sub = 1'b0;
        bus.in_valid   = 1'b0;
        #2;
        check_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send("ex_13p92", 32'h415EB852, 32'h40DEB852, 1'b0, 32'h41A70A3D, 1'b0);
        send("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
        send("three_m_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0);
        send("one_m_two", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0);
        send("one_m_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0);
        send("inf_a", 32'h7F800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b1);
        send("nan_b", 32'h3F800000, 32'h7FC00000, 1'b1, 32'h00000000, 1'b1);
        send("two_p_m1", 32'h40000000, 32'hBF800000, 1'b0, 32'h3F800000, 1'b0);
        send("m3_p_1", 32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000, 1'b0);
        send("tie_neg_a", 32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b0);
        send("one_m_m1", 32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 1'b0);
        send("ovf_pos", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0);
        send("ovf_neg", 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 1'b0);
        send("shift23", 32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 1'b0);
        send("shift24", 32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0);
        send("flush_lo", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0);
        send("zero_zero", 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
        send("last_val", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0);

        idle(LAT + 1);
        check_hold("hold");

        send("burst0", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
        send("burst1", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0);
        send("burst2", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0);
        send("burst3", 32'h40800000, 32'h3F800000, 1'b0, 32'h40A00000, 1'b0);
        bus.a_operand = 32'h40A00000;
        #3;
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        exp_res_q.delete();
        exp_exc_q.delete();
        tag_q.delete();
        tick();
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        check_zero("post_release");

        send("first_after", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0);
        idle(LAT + 2);

        total++;
        assert (exp_res_q.size() == 0) else begin
            bad++;
            $error("FAIL drain pending got=%0d want=0", exp_res_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
